usb_packet_tx: RTL and testbench
================================

USB_PACKET_TX -- requirements
Module: usb_packet_tx

Interface
REQ-001 SHALL have parameter HEADER_KEY_SYMBOL, default 85, meaning header byte value.
REQ-002 SHALL have parameter HEADER_KEY_SYMBOL_NUMBER, default 12, meaning header byte count.
REQ-003 SHALL have parameter TRAILER_KEY_SYMBOL, default 170, meaning trailer byte value.
REQ-004 SHALL have parameter TRAILER_KEY_SYMBOL_NUMBER, default 8, meaning trailer byte count.
REQ-005 SHALL have parameter WR_PULSE_CYCLES, default 4, meaning FT_WR high time in clk cycles (legal range 1..15).
REQ-006 SHALL have parameter RECOVER_CYCLES, default 4, meaning FT_WR low time after each byte before FT_TXEn is sampled again (legal range 1..15).
REQ-007 SHALL have parameter TXE_TIMEOUT, default 1024, meaning the maximum number of cycles to wait for FT_TXEn low.
REQ-008 SHALL have a single clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle packet request.
- word_count  in  8  number of 16-bit payload words (0..255); latched when start is accepted.
- tx_data  in  16  payload word.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  word accepted this cycle.
- busy  out  1  packet in progress.
- done  out  1  one-cycle pulse on packet completion.
- error  out  1  sticky TXE timeout flag.
- FT_TXEn  in  1  FT245 TXE#, asynchronous, low means room in the FIFO.
- FT_WR  out  1  FT245 WR strobe; the byte is latched on its falling edge.
- FT_DATA_Out  out  8  FT245 data byte.
- FT_DATA_Oe  out  1  data bus drive enable.

Function
REQ-009 SHALL synchronize FT_TXEn through 2 flip-flops, and SHALL use only the synchronized value.
REQ-010 SHALL emit, in order: HEADER_KEY_SYMBOL_NUMBER header bytes; 2*word_count payload bytes, high byte first; then TRAILER_KEY_SYMBOL_NUMBER trailer bytes.
REQ-011 SHALL run a top FSM with states IDLE, HEADER, PAYLOAD, TRAILER and DONE, and a byte sub-FSM with states WAIT_TXE, STROBE and RECOVER.
REQ-012 SHALL accept start only in IDLE, and SHALL ignore start while busy.
REQ-013 SHALL run the byte sub-FSM as follows.
- WAIT_TXE: wait for synchronized FT_TXEn low.
- STROBE: FT_DATA_Out stable, FT_WR=1 for WR_PULSE_CYCLES.
- RECOVER: FT_WR=0 for RECOVER_CYCLES, with FT_DATA_Out held.
REQ-014 SHALL hold FT_DATA_Out stable from 1 cycle before FT_WR rises until the end of RECOVER.
REQ-015 SHALL, with synchronized FT_TXEn already low, raise FT_WR on the second rising edge after the edge that samples start.
REQ-016 SHALL give a byte period of WR_PULSE_CYCLES+RECOVER_CYCLES+1 cycles when FT_TXEn stays low.
REQ-017 SHALL assert tx_ready for exactly 1 cycle, only in PAYLOAD, when tx_valid=1 and the next high byte is due; the word is latched on that cycle.
REQ-018 SHALL stall in PAYLOAD while tx_valid=0, with FT_WR=0 and no timeout counted.
REQ-019 SHALL, when word_count=0, go from HEADER directly to TRAILER, and SHALL never assert tx_ready.
REQ-020 SHALL count cycles in WAIT_TXE; on reaching TXE_TIMEOUT it SHALL set error, return to IDLE, hold FT_WR=0, and not pulse done.
REQ-021 SHALL clear error when the next start is accepted.
REQ-022 SHALL, in DONE, pulse done for 1 cycle and then enter IDLE; busy=1 in every state except IDLE.
REQ-023 SHALL assert FT_DATA_Oe whenever busy=1.
REQ-024 SHALL register all outputs, and SHALL drive FT_WR from a flip-flop with no combinational glitch.

Reset
REQ-025 SHALL, while rst=1, immediately force FT_WR=0, FT_DATA_Out=0, FT_DATA_Oe=0, tx_ready=0, busy=0, done=0 and error=0, with both FSMs in IDLE/WAIT_TXE and all counters at 0.
REQ-026 SHALL, on reset mid-packet, abandon the packet without emitting further bytes, and SHALL return to IDLE.

Configuration
REQ-027 SHALL, with USB_TX_CHECKSUM_EN defined, send one extra byte after the last payload byte and before the trailer: the 8-bit XOR of all payload bytes (0x00 when word_count=0).
REQ-028 SHALL, without USB_TX_CHECKSUM_EN, emit no checksum byte and include no checksum logic.

Verification
REQ-029 SHALL cover: FT_TXEn=0 held, start with word_count=2, words 0x0045 and 0x1000 -> bytes 12x55, 00 45 10 00, 8xAA; done after 24 strobes.
REQ-030 SHALL cover: word_count=0 -> 12x55 then 8xAA, tx_ready never asserted, done pulses once.
REQ-031 SHALL cover: FT_TXEn held high for 1024 cycles after start -> error=1, FT_WR=0, no done; next start clears error.
REQ-032 SHALL cover: tx_valid withheld 50 cycles mid-PAYLOAD -> FT_WR stays 0, no error; the packet resumes correctly.
REQ-033 SHALL cover: rst asserted during STROBE of the 5th header byte -> FT_WR=0 in the same cycle, busy=0; a new start sends a full packet.
REQ-034 SHALL cover, with USB_TX_CHECKSUM_EN: words 0xABCD and 0x0010 -> checksum byte 0x76 before the trailer.

Source files
------------

// File: rtl/usb_packet_tx.sv
// usb_packet_tx: frames a burst of 16-bit payload words into an FT245-style
// byte stream: a run of header key bytes, the payload (high byte first) and
// a run of trailer key bytes.
//
// Each byte is sent by a small sub-FSM with three states:
//   WAIT_TXE  - wait until the FIFO reports free space
//   STROBE    - drive FT_WR high
//   RECOVER   - drive FT_WR low again
// FT_DATA_Out is loaded one cycle before FT_WR rises and stays unchanged
// until RECOVER ends.
//
// Optional feature (macro USB_TX_CHECKSUM_EN): after the payload, one extra
// byte is sent before the trailer. It is the XOR of all payload bytes.
module usb_packet_tx #(
  parameter int HEADER_KEY_SYMBOL         = 85,
  parameter int HEADER_KEY_SYMBOL_NUMBER  = 12,
  parameter int TRAILER_KEY_SYMBOL        = 170,
  parameter int TRAILER_KEY_SYMBOL_NUMBER = 8,
  parameter int WR_PULSE_CYCLES           = 4,
  parameter int RECOVER_CYCLES            = 4,
  parameter int TXE_TIMEOUT               = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  word_count,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic        FT_TXEn,
  output logic        FT_WR,
  output logic [7:0]  FT_DATA_Out,
  output logic        FT_DATA_Oe
);

  localparam int TO_W = (TXE_TIMEOUT > 1) ? $clog2(TXE_TIMEOUT) : 1;
  localparam logic [7:0]      HDR_BYTE  = 8'(HEADER_KEY_SYMBOL);
  localparam logic [7:0]      TRL_BYTE  = 8'(TRAILER_KEY_SYMBOL);
  localparam logic [8:0]      HDR_LAST  = 9'(HEADER_KEY_SYMBOL_NUMBER - 1);
  localparam logic [8:0]      TRL_NUM   = 9'(TRAILER_KEY_SYMBOL_NUMBER);
  localparam logic [3:0]      WR_LAST   = 4'(WR_PULSE_CYCLES - 1);
  localparam logic [3:0]      REC_LAST  = 4'(RECOVER_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TXE_TIMEOUT - 1);

  // The top state names the section that the next byte to be loaded
  // belongs to. It therefore moves ahead of the byte currently on the wire.
  typedef enum logic [2:0] {
    T_IDLE     = 3'd0,
    T_HEADER   = 3'd1,
    T_PAYLOAD  = 3'd2,
    T_TRAILER  = 3'd3,
    T_DONE     = 3'd4
`ifdef USB_TX_CHECKSUM_EN
    , T_CHECKSUM = 3'd5
`endif
  } top_t;

  typedef enum logic [1:0] {
    S_WAIT_TXE = 2'd0,
    S_STROBE   = 2'd1,
    S_RECOVER  = 2'd2
  } sub_t;

  top_t            r_top;
  sub_t            r_sub;
  logic            r_txe_meta;
  logic            r_txe_sync;
  logic [7:0]      r_wc;
  logic [8:0]      r_cnt;        // bytes already loaded in the current section
  logic [7:0]      r_fetched;    // payload words taken so far
  logic [15:0]     r_word;
  logic            r_have_word;  // r_word still holds a byte that has not been loaded
  logic            r_data_ok;    // FT_DATA_Out holds the byte due next
  logic [3:0]      r_pulse_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_tx_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_error;
  logic            r_wr;
  logic [7:0]      r_data;
  logic            r_oe;
`ifdef USB_TX_CHECKSUM_EN
  logic [7:0]      r_csum;
`endif

  logic            w_avail;
  logic [7:0]      w_byte;
  logic            w_load;
  logic            w_rec_end;
  logic [8:0]      w_pay_last;
  top_t            w_after_payload;

  assign tx_ready    = r_tx_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign FT_WR       = r_wr;
  assign FT_DATA_Out = r_data;
  assign FT_DATA_Oe  = r_oe;

  assign w_pay_last = {r_wc, 1'b0} - 9'd1;
  assign w_rec_end  = (r_sub == S_RECOVER) && (r_pulse_cnt == REC_LAST);

  // A byte is loaded when RECOVER ends, or while waiting if the byte was not yet available.
  assign w_load = w_avail &&
                  (((r_sub == S_WAIT_TXE) && !r_data_ok) || w_rec_end);

  // Two-flop synchronizer for the asynchronous FIFO-full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txe_meta <= 1'b1;
      r_txe_sync <= 1'b1;
    end else begin
      r_txe_meta <= FT_TXEn;
      r_txe_sync <= r_txe_meta;
    end
  end

  // Choose the section that follows the payload.
  always_comb begin
`ifdef USB_TX_CHECKSUM_EN
    w_after_payload = T_CHECKSUM;
`else
    w_after_payload = T_TRAILER;
`endif
  end

  // Select the next byte and check whether it is available now.
  always_comb begin
    w_avail = 1'b0;
    w_byte  = 8'h00;
    case (r_top)
      T_HEADER: begin
        w_avail = 1'b1;
        w_byte  = HDR_BYTE;
      end
      T_PAYLOAD: begin
        if (r_cnt[0] == 1'b0) begin
          w_avail = r_have_word;
          w_byte  = r_word[15:8];
        end else begin
          w_avail = 1'b1;
          w_byte  = r_word[7:0];
        end
      end
`ifdef USB_TX_CHECKSUM_EN
      T_CHECKSUM: begin
        w_avail = 1'b1;
        w_byte  = r_csum;
      end
`endif
      T_TRAILER: begin
        w_avail = (r_cnt < TRL_NUM);
        w_byte  = TRL_BYTE;
      end
      default: begin
        w_avail = 1'b0;
        w_byte  = 8'h00;
      end
    endcase
  end

  // Packet sequencer, byte strobe engine and payload word fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_top       <= T_IDLE;
      r_sub       <= S_WAIT_TXE;
      r_wc        <= 8'd0;
      r_cnt       <= 9'd0;
      r_fetched   <= 8'd0;
      r_word      <= 16'h0000;
      r_have_word <= 1'b0;
      r_data_ok   <= 1'b0;
      r_pulse_cnt <= 4'd0;
      r_to_cnt    <= '0;
      r_tx_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_wr        <= 1'b0;
      r_data      <= 8'h00;
      r_oe        <= 1'b0;
`ifdef USB_TX_CHECKSUM_EN
      r_csum      <= 8'h00;
`endif
    end else begin
      r_done <= 1'b0;

      // Fetch the next word ahead of time. Fetching starts as soon as the
      // previous word's low byte has been loaded, so a steady data source
      // never stalls the byte stream.
      if (r_tx_ready) begin
        r_tx_ready  <= 1'b0;
        r_word      <= tx_data;
        r_have_word <= 1'b1;
        r_fetched   <= r_fetched + 8'd1;
      end else if ((r_top == T_PAYLOAD) && !r_have_word && tx_valid &&
                   (r_fetched < r_wc)) begin
        r_tx_ready <= 1'b1;
      end else begin
        r_tx_ready <= 1'b0;
      end

      case (r_top)
        T_IDLE: begin
          if (start) begin
            r_top       <= T_HEADER;
            r_sub       <= S_WAIT_TXE;
            r_busy      <= 1'b1;
            r_oe        <= 1'b1;
            r_error     <= 1'b0;
            r_wc        <= word_count;
            r_cnt       <= 9'd0;
            r_fetched   <= 8'd0;
            r_have_word <= 1'b0;
            r_data_ok   <= 1'b0;
            r_pulse_cnt <= 4'd0;
            r_to_cnt    <= '0;
`ifdef USB_TX_CHECKSUM_EN
            r_csum      <= 8'h00;
`endif
          end else begin
            r_busy <= 1'b0;
          end
        end
        T_DONE: begin
          r_top  <= T_IDLE;
          r_busy <= 1'b0;
          r_oe   <= 1'b0;
        end
        default: begin
          case (r_sub)
            S_WAIT_TXE: begin
              if (r_data_ok) begin
                if (!r_txe_sync) begin
                  r_sub       <= S_STROBE;
                  r_wr        <= 1'b1;
                  r_pulse_cnt <= 4'd0;
                  r_to_cnt    <= '0;
                end else if (r_to_cnt == TO_LAST) begin
                  r_error     <= 1'b1;
                  r_top       <= T_IDLE;
                  r_busy      <= 1'b0;
                  r_oe        <= 1'b0;
                  r_wr        <= 1'b0;
                  r_data_ok   <= 1'b0;
                  r_to_cnt    <= '0;
                  r_tx_ready  <= 1'b0;
                end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
                end
              end else begin
                r_to_cnt <= '0;
              end
            end
            S_STROBE: begin
              if (r_pulse_cnt == WR_LAST) begin
                r_wr        <= 1'b0;
                r_sub       <= S_RECOVER;
                r_pulse_cnt <= 4'd0;
              end else begin
                r_pulse_cnt <= r_pulse_cnt + 4'd1;
              end
            end
            S_RECOVER: begin
              if (r_pulse_cnt == REC_LAST) begin
                r_pulse_cnt <= 4'd0;
                r_sub       <= S_WAIT_TXE;
                r_data_ok   <= 1'b0;
                // The trailer has no bytes left only after its last byte was sent.
                if (!w_avail && (r_top == T_TRAILER)) begin
                  r_top  <= T_DONE;
                  r_done <= 1'b1;
                end
              end else begin
                r_pulse_cnt <= r_pulse_cnt + 4'd1;
              end
            end
            default: begin
              r_sub <= S_WAIT_TXE;
              r_wr  <= 1'b0;
            end
          endcase

          // Load the next byte. The section counters advance as each byte
          // is loaded, not when it is strobed.
          if (w_load) begin
            r_data    <= w_byte;
            r_data_ok <= 1'b1;
            case (r_top)
              T_HEADER: begin
                if (r_cnt == HDR_LAST) begin
                  r_cnt <= 9'd0;
                  r_top <= (r_wc == 8'd0) ? w_after_payload : T_PAYLOAD;
                end else begin
                  r_cnt <= r_cnt + 9'd1;
                end
              end
              T_PAYLOAD: begin
`ifdef USB_TX_CHECKSUM_EN
                r_csum <= r_csum ^ w_byte;
`endif
                if (r_cnt[0]) begin
                  r_have_word <= 1'b0;
                end else begin
                  r_have_word <= r_have_word;
                end
                if (r_cnt == w_pay_last) begin
                  r_cnt <= 9'd0;
                  r_top <= w_after_payload;
                end else begin
                  r_cnt <= r_cnt + 9'd1;
                end
              end
`ifdef USB_TX_CHECKSUM_EN
              T_CHECKSUM: begin
                r_cnt <= 9'd0;
                r_top <= T_TRAILER;
              end
`endif
              T_TRAILER: begin
                r_cnt <= r_cnt + 9'd1;
              end
              default: begin
                r_cnt <= r_cnt;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_packet_tx.sv
// Self-checking bench for usb_packet_tx. The reference model builds the
// expected byte list of each packet from the packet format. A monitor then
// checks every strobed byte, the strobe timing and the data hold window.
module tb_usb_packet_tx;

  localparam int HN   = 12;
  localparam int TN   = 8;
  localparam int WRC  = 4;
  localparam int RECC = 4;
  localparam int TO   = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  word_count;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic        FT_TXEn;
  logic        FT_WR;
  logic [7:0]  FT_DATA_Out;
  logic        FT_DATA_Oe;

  usb_packet_tx dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .error(error), .FT_TXEn(FT_TXEn),
    .FT_WR(FT_WR), .FT_DATA_Out(FT_DATA_Out), .FT_DATA_Oe(FT_DATA_Oe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] feed_q[$];
  int rise_cnt, done_cnt, ready_cnt, last_rise, first_rise_cyc, start_cyc;
  bit period_chk = 1'b0;
  bit valid_always = 1'b1;
  int txe_mode = 0;
  int stall_word = -1;
  int stall_left = 0;
  bit stall_watch = 1'b0;
  int stall_wr_hits = 0;
  int words_sent = 0;
  bit adv = 1'b0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: the expected bytes of one packet.
  task automatic push_expected(input int wc, input logic [15:0] words[$]);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < HN; i++) exp_q.push_back(8'h55);
    for (int i = 0; i < wc; i++) begin
      exp_q.push_back(words[i][15:8]);
      exp_q.push_back(words[i][7:0]);
      x = x ^ words[i][15:8] ^ words[i][7:0];
    end
`ifdef USB_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    for (int i = 0; i < TN; i++) exp_q.push_back(8'hAA);
  endtask

  // Monitor: checks strobed bytes, strobe timing, data hold and done.
  logic       m_prev_wr, m_prev_done;
  logic [7:0] m_prev_data, m_held, m_e;
  int         m_win, m_hi;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_prev_wr = 1'b0; m_prev_done = 1'b0; m_prev_data = 8'h00; m_win = 0; m_hi = 0;
    end else begin
      if (FT_WR && !m_prev_wr) begin
        rise_cnt++;
        if (exp_q.size() == 0) chk(1'b0, "extra_byte", FT_DATA_Out, 0);
        else begin
          m_e = exp_q.pop_front();
          chk(FT_DATA_Out == m_e, "byte_value", FT_DATA_Out, m_e);
        end
        chk(FT_DATA_Out == m_prev_data, "data_setup", FT_DATA_Out, m_prev_data);
        if (rise_cnt == 1) first_rise_cyc = cyc;
        else if (period_chk) chk(cyc - last_rise == WRC + RECC + 1, "byte_period", cyc - last_rise, WRC + RECC + 1);
        last_rise = cyc;
        m_held = FT_DATA_Out;
        m_win = WRC + RECC - 1;
        m_hi = 1;
      end else begin
        if (m_win > 0) begin
          if (FT_DATA_Out != m_held) chk(1'b0, "data_hold", FT_DATA_Out, m_held);
          m_win--;
        end
        if (FT_WR) m_hi++;
        if (!FT_WR && m_prev_wr) chk(m_hi == WRC, "wr_high_width", m_hi, WRC);
      end
      if (tx_ready) begin
        ready_cnt++;
        if (!tx_valid) chk(1'b0, "ready_without_valid", 0, 1);
      end
      if (done) begin
        done_cnt++;
        chk(exp_q.size() == 0, "done_after_all_bytes", exp_q.size(), 0);
        if (m_prev_done) chk(1'b0, "done_width", 2, 1);
      end
      if (stall_watch && FT_WR) stall_wr_hits++;
      m_prev_wr = FT_WR; m_prev_data = FT_DATA_Out; m_prev_done = done;
    end
  end

  // FT_TXEn driver: held low, held high, or mostly low with short high bursts.
  initial begin
    FT_TXEn = 1'b0;
    forever begin
      @(negedge clk);
      case (txe_mode)
        1:       FT_TXEn = 1'b1;
        2:       FT_TXEn = ($urandom_range(0, 3) == 0);
        default: FT_TXEn = 1'b0;
      endcase
    end
  end

  // Word feeder. tx_valid stays high until the word has been taken, and the
  // word stays on tx_data through the tx_ready cycle.
  initial begin
    tx_valid = 1'b0;
    tx_data  = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        adv = 1'b0; tx_valid = 1'b0;
      end else if (tx_ready) begin
        adv = 1'b1;
      end else begin
        if (adv) begin
          if (feed_q.size() > 0) void'(feed_q.pop_front());
          adv = 1'b0; tx_valid = 1'b0; words_sent++;
        end
        if (!tx_valid && feed_q.size() > 0) begin
          if (words_sent == stall_word && stall_left > 0) begin
            stall_left--;
            stall_watch = (stall_left < 20);
          end else if (valid_always || $urandom_range(0, 2) != 0) begin
            tx_data = feed_q[0]; tx_valid = 1'b1; stall_watch = 1'b0;
          end
        end
      end
    end
  end

  task automatic flush();
    feed_q.delete(); exp_q.delete(); tx_valid = 1'b0; adv = 1'b0;
  endtask

  task automatic send_start(input int wc);
    rise_cnt = 0; done_cnt = 0; ready_cnt = 0; words_sent = 0;
    @(negedge clk); #1;
    start = 1'b1; word_count = 8'(wc); start_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    chk(error == 1'b0, "error_clear_on_start", error, 0);
    chk(busy == 1'b1 && FT_DATA_Oe == 1'b1, "busy_oe_after_start", {busy, FT_DATA_Oe}, 3);
  endtask

  task automatic run_packet(input int wc, input int nbytes);
    int n;
    send_start(wc);
    n = 0;
    while (done_cnt == 0 && n < nbytes * (WRC + RECC + 1) * 4 + 400) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    chk(done_cnt == 1, "done_once", done_cnt, 1);
    chk(ready_cnt == wc, "ready_count", ready_cnt, wc);
    chk(rise_cnt == nbytes, "strobe_count", rise_cnt, nbytes);
    chk(busy == 1'b0 && FT_DATA_Oe == 1'b0, "idle_after_done", {busy, FT_DATA_Oe}, 0);
  endtask

  int csum_extra;
  logic [15:0] words[$];
  int wc, n;

  initial begin
`ifdef USB_TX_CHECKSUM_EN
    csum_extra = 1;
`else
    csum_extra = 0;
`endif
    rst = 1'b1; start = 1'b0; word_count = 8'd0;
    repeat (3) @(negedge clk);
    chk(FT_WR == 1'b0, "rst_wr", FT_WR, 0);
    chk(FT_DATA_Out == 8'h00, "rst_data", FT_DATA_Out, 0);
    chk(FT_DATA_Oe == 1'b0, "rst_oe", FT_DATA_Oe, 0);
    chk(tx_ready == 1'b0, "rst_ready", tx_ready, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(done == 1'b0, "rst_done", done, 0);
    chk(error == 1'b0, "rst_error", error, 0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Two words with hand-written expected bytes; checks period and first-strobe latency.
    txe_mode = 0; valid_always = 1'b1; period_chk = 1'b1;
    feed_q.push_back(16'h0045); feed_q.push_back(16'h1000);
    for (int i = 0; i < 12; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'h00); exp_q.push_back(8'h45); exp_q.push_back(8'h10); exp_q.push_back(8'h00);
`ifdef USB_TX_CHECKSUM_EN
    exp_q.push_back(8'h55);
`endif
    for (int i = 0; i < 8; i++) exp_q.push_back(8'hAA);
    run_packet(2, 24 + csum_extra);
    chk(first_rise_cyc == start_cyc + 3, "first_wr_latency", first_rise_cyc - start_cyc, 3);

    // Zero-length payload.
    flush(); words.delete();
    push_expected(0, words);
    run_packet(0, 20 + csum_extra);

`ifdef USB_TX_CHECKSUM_EN
    // Checksum byte: AB^CD^00^10 = 76.
    flush();
    feed_q.push_back(16'hABCD); feed_q.push_back(16'h0010);
    for (int i = 0; i < 12; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hAB); exp_q.push_back(8'hCD); exp_q.push_back(8'h00); exp_q.push_back(8'h10);
    exp_q.push_back(8'h76);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'hAA);
    run_packet(2, 25);
`endif

    // TXE timeout: FT_TXEn held high.
    flush(); period_chk = 1'b0; txe_mode = 1;
    repeat (4) @(negedge clk);
    feed_q.push_back(16'h1234);
    send_start(1);
    repeat (1005) @(negedge clk);
    chk(error == 1'b0, "no_early_timeout", error, 0);
    repeat (45) @(negedge clk);
    chk(error == 1'b1, "timeout_error", error, 1);
    chk(FT_WR == 1'b0, "timeout_wr_low", FT_WR, 0);
    chk(busy == 1'b0, "timeout_idle", busy, 0);
    chk(done_cnt == 0, "timeout_no_done", done_cnt, 0);
    chk(rise_cnt == 0, "timeout_no_strobe", rise_cnt, 0);
    flush(); txe_mode = 0;
    repeat (4) @(negedge clk);
    words.delete(); words.push_back(16'hBEEF);
    feed_q = words; push_expected(1, words);
    run_packet(1, 22 + csum_extra);

    // tx_valid withheld for 50 cycles before word 1.
    flush(); words.delete();
    for (int i = 0; i < 4; i++) words.push_back(16'($urandom));
    feed_q = words; push_expected(4, words);
    stall_word = 1; stall_left = 50; stall_wr_hits = 0;
    run_packet(4, 28 + csum_extra);
    chk(stall_wr_hits == 0, "stall_wr_quiet", stall_wr_hits, 0);
    chk(error == 1'b0, "stall_no_error", error, 0);
    stall_word = -1;

    // Reset during STROBE of the fifth header byte.
    flush(); words.delete();
    for (int i = 0; i < 3; i++) words.push_back(16'($urandom));
    feed_q = words; push_expected(3, words);
    send_start(3);
    n = 0;
    while (rise_cnt < 5 && n < 200) begin @(negedge clk); n++; end
    chk(rise_cnt == 5 && FT_WR == 1'b1, "reached_5th_strobe", rise_cnt, 5);
    #2 rst = 1'b1;
    #1;
    chk(FT_WR == 1'b0, "rst_mid_wr", FT_WR, 0);
    chk(busy == 1'b0, "rst_mid_busy", busy, 0);
    @(negedge clk); #1 rst = 1'b0;
    flush();
    repeat (3) @(negedge clk);
    chk(rise_cnt == 5, "no_bytes_after_reset", rise_cnt, 5);
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back(16'($urandom));
    feed_q = words; push_expected(3, words);
    run_packet(3, 26 + csum_extra);

    // Randomized packets with random FT_TXEn and tx_valid.
    txe_mode = 2; valid_always = 1'b0;
    for (int p = 0; p < 6; p++) begin
      flush(); words.delete();
      wc = (p == 5) ? 255 : $urandom_range(0, 20);
      for (int i = 0; i < wc; i++) words.push_back(16'($urandom));
      feed_q = words; push_expected(wc, words);
      run_packet(wc, HN + TN + 2 * wc + csum_extra);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
